// File: rtl/calc_pkg.sv
// Shared key codes, operation encodings and FSM state encoding for the
// calculator key-entry front end.
package calc_pkg;

   localparam logic [3:0] KEY_ADD    = 4'd8;
   localparam logic [3:0] KEY_SUB    = 4'd9;
   localparam logic [3:0] KEY_MUL    = 4'd10;
   localparam logic [3:0] KEY_DIV    = 4'd11;
   localparam logic [3:0] KEY_ENTER  = 4'd12;
   localparam logic [3:0] KEY_CLEAR  = 4'd13;
   localparam logic [3:0] KEY_RECALL = 4'd14;
   localparam logic [3:0] KEY_RSVD   = 4'd15;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int LOAD_CYCLES_MIN = 1;
   localparam int LOAD_CYCLES_MAX = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GOT_A  = 3'd1,
      ST_GOT_OP = 3'd2,
      ST_GOT_B  = 3'd3,
      ST_LOAD   = 3'd4,
      ST_HOLD   = 3'd5
   } state_t;

   // States in which a presented key is consumed.
   function automatic logic accepting(input state_t s);
      return (s == ST_IDLE) || (s == ST_GOT_A) || (s == ST_GOT_OP) || (s == ST_GOT_B);
   endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Combinational classification of a 4-bit key code into key classes.
module calc_key_decode
   import calc_pkg::*;
(
   input  logic [3:0] key_code,
   output logic       is_digit,
   output logic       is_op,
   output logic [1:0] op_val,
   output logic       is_enter,
   output logic       is_clear,
   output logic       is_recall
);

   // Digits are 0-7 and operators 8-11, so the top bits classify them directly.
   assign is_digit  = ~key_code[3];
   assign is_op     = (key_code[3:2] == 2'b10);
   assign op_val    = key_code[1:0];
   assign is_enter  = (key_code == KEY_ENTER);
   assign is_clear  = (key_code == KEY_CLEAR);
   assign is_recall = (key_code == KEY_RECALL);

endmodule

// File: rtl/calc_key_entry.sv
// Key-entry sequencer: stages operand A, operator and operand B from a keypad,
// commits them on ENTER and issues a load strobe to the calculator.
module calc_key_entry
   import calc_pkg::*;
#(
   parameter int LOAD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic [2:0] a,
   output logic [2:0] b,
   output logic [1:0] op,
   output logic       load,
   output logic       addr,
   output logic       err,
   output logic [3:0] drop_cnt
);

   localparam int LC_EFF = (LOAD_CYCLES < LOAD_CYCLES_MIN) ? LOAD_CYCLES_MIN :
                           (LOAD_CYCLES > LOAD_CYCLES_MAX) ? LOAD_CYCLES_MAX : LOAD_CYCLES;
   localparam logic [3:0] LOAD_LAST = 4'(LC_EFF - 1);

   state_t     state_q, state_d;
   logic [2:0] sa_q, sa_d, sb_q, sb_d;
   logic [1:0] sop_q, sop_d;
   logic [2:0] a_q, a_d, b_q, b_d;
   logic [1:0] op_q, op_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] drop_q, drop_d;
   logic       addr_q, addr_d;
   logic       err_q, err_d;
   logic       ready_q, load_q;
   logic       accept;

   logic       is_digit, is_op, is_enter, is_clear, is_recall;
   logic [1:0] op_val;

   calc_key_decode u_dec (
      .key_code  (key_code),
      .is_digit  (is_digit),
      .is_op     (is_op),
      .op_val    (op_val),
      .is_enter  (is_enter),
      .is_clear  (is_clear),
      .is_recall (is_recall)
   );

   assign accept = key_valid & ready_q;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sop_d   = sop_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      drop_d  = drop_q;
      addr_d  = addr_q;
      err_d   = 1'b0;

      if (key_valid && !ready_q && (drop_q != 4'hF))
         drop_d = drop_q + 4'd1;

      case (state_q)
         ST_LOAD: begin
            if (cnt_q == LOAD_LAST) state_d = ST_HOLD;
            else                    cnt_d   = cnt_q + 4'd1;
         end
         ST_HOLD:                                   state_d = ST_IDLE;
         ST_IDLE, ST_GOT_A, ST_GOT_OP, ST_GOT_B:    ;
         default:                                   state_d = ST_IDLE;
      endcase

      // CLEAR and RECALL take precedence over the per-state sequencing.
      if (accept) begin
         if (is_clear) begin
            state_d = ST_IDLE;
            sa_d    = 3'd0;
            sb_d    = 3'd0;
            sop_d   = OP_ADD;
         end else if (is_recall) begin
            addr_d = ~addr_q;
         end else if (is_digit) begin
            case (state_q)
               ST_IDLE:   begin sa_d = key_code[2:0]; state_d = ST_GOT_A; end
               ST_GOT_A:  sa_d = key_code[2:0];
               ST_GOT_OP: begin sb_d = key_code[2:0]; state_d = ST_GOT_B; end
               ST_GOT_B:  sb_d = key_code[2:0];
               default:   ;
            endcase
         end else if (is_op) begin
            if ((state_q == ST_GOT_A) || (state_q == ST_GOT_OP)) begin
               sop_d   = op_val;
               state_d = ST_GOT_OP;
            end else begin
               err_d = 1'b1;
            end
         end else if (is_enter) begin
            if (state_q == ST_GOT_B) begin
               a_d     = sa_q;
               b_d     = sb_q;
               op_d    = sop_q;
               cnt_d   = 4'd0;
               state_d = ST_LOAD;
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sa_q    <= 3'd0;
         sb_q    <= 3'd0;
         sop_q   <= OP_ADD;
         a_q     <= 3'd0;
         b_q     <= 3'd0;
         op_q    <= OP_ADD;
         cnt_q   <= 4'd0;
         drop_q  <= 4'd0;
         addr_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sop_q   <= sop_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         ready_q <= accepting(state_d);
         load_q  <= (state_d == ST_LOAD);
      end
   end

   assign key_ready = ready_q;
   assign a         = a_q;
   assign b         = b_q;
   assign op        = op_q;
   assign load      = load_q;
   assign addr      = addr_q;
   assign err       = err_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Scenario and randomized checks of calc_key_entry against a behavioural
// model tracking which entry fields are filled and how long the unit is busy.
module tb_calc_key_entry;

   localparam int LC = 4;

   logic       clk = 1'b0;
   logic       rst, key_valid;
   logic [3:0] key_code;
   logic       key_ready, load, addr, err;
   logic [2:0] a, b;
   logic [1:0] op;
   logic [3:0] drop_cnt;
   logic [15:0] act_vec;

   int total = 0;
   int bad   = 0;

   int m_a, m_b, m_op, s_a, s_b, s_op, busy, m_addr, m_err, m_drop;
   bit have_a, have_op, have_b;

   calc_key_entry #(.LOAD_CYCLES(LC)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .load      (load),
      .addr      (addr),
      .err       (err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   assign act_vec = {key_ready, a, b, op, load, addr, err, drop_cnt};

   // busy counts the non-accepting cycles left: LC load cycles then one hold.
   function automatic logic [15:0] exp_vec();
      return {(busy == 0), 3'(m_a), 3'(m_b), 2'(m_op), (busy >= 2),
              1'(m_addr), 1'(m_err), 4'(m_drop)};
   endfunction

   task automatic model_update(input logic v, input int c, input logic r);
      if (r) begin
         m_a = 0; m_b = 0; m_op = 0; s_a = 0; s_b = 0; s_op = 0;
         busy = 0; m_addr = 0; m_err = 0; m_drop = 0;
         have_a = 0; have_op = 0; have_b = 0;
         return;
      end
      m_err = 0;
      if (busy > 0) begin
         busy = busy - 1;
         if (v && m_drop < 15) m_drop = m_drop + 1;
      end else if (v) begin
         if (c == 13) begin
            have_a = 0; have_op = 0; have_b = 0; s_a = 0; s_b = 0; s_op = 0;
         end else if (c == 14) begin
            m_addr = 1 - m_addr;
         end else if (c == 15) begin
         end else if (c < 8) begin
            if (!have_op) begin s_a = c; have_a = 1; end
            else begin s_b = c; have_b = 1; end
         end else if (c < 12) begin
            if (have_a && !have_b) begin s_op = c - 8; have_op = 1; end
            else m_err = 1;
         end else begin
            if (have_b) begin
               m_a = s_a; m_b = s_b; m_op = s_op; busy = LC + 1;
               have_a = 0; have_op = 0; have_b = 0;
            end else m_err = 1;
         end
      end
   endtask

   task automatic step(input logic v, input int c, input logic r);
      key_valid = v;
      key_code  = 4'(c);
      rst       = r;
      @(posedge clk);
      model_update(v, c, r);
      #1;
      key_valid = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b1, 5, 1'b1);
      step(1'b0, 0, 1'b1);
      total++;
      if (act_vec !== 16'h8000) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", act_vec, 16'h8000);
      end
      step(1'b0, 0, 1'b0);
      total++;
      if (act_vec !== exp_vec()) begin
         bad++; $display("FAIL reset_idle got=%h exp=%h", act_vec, exp_vec());
      end
   endtask

   task automatic test_basic();
      int loads;
      step(1'b1, 5, 1'b0); step(1'b1, 8, 1'b0); step(1'b1, 3, 1'b0);
      step(1'b1, 12, 1'b0);
      total++;
      if ({a, b, op, load} !== {3'b101, 3'b011, 2'b00, 1'b1}) begin
         bad++; $display("FAIL basic_commit got a=%b b=%b op=%b load=%b exp a=101 b=011 op=00 load=1",
                         a, b, op, load);
      end
      loads = 1;
      for (int i = 0; i < LC + 1; i++) begin
         step(1'b0, 0, 1'b0);
         if (load) loads++;
         total++;
         if (act_vec !== exp_vec()) begin
            bad++; $display("FAIL basic_drain[%0d] got=%h exp=%h", i, act_vec, exp_vec());
         end
      end
      total++;
      if (loads !== LC) begin
         bad++; $display("FAIL basic_load_width got=%0d exp=%0d", loads, LC);
      end
   endtask

   task automatic test_last_wins();
      step(1'b1, 6, 1'b0); step(1'b1, 9, 1'b0); step(1'b1, 10, 1'b0);
      step(1'b1, 2, 1'b0); step(1'b1, 1, 1'b0); step(1'b1, 12, 1'b0);
      total++;
      if ({a, b, op} !== {3'b110, 3'b001, 2'b10}) begin
         bad++; $display("FAIL last_wins got a=%b b=%b op=%b exp a=110 b=001 op=10", a, b, op);
      end
      for (int i = 0; i < LC + 1; i++) begin
         step(1'b0, 0, 1'b0);
         total++;
         if (act_vec !== exp_vec()) begin
            bad++; $display("FAIL last_wins_drain[%0d] got=%h exp=%h", i, act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_errors();
      step(1'b1, 12, 1'b0);
      total++;
      if (err !== 1'b1 || act_vec !== exp_vec()) begin
         bad++; $display("FAIL err_enter_idle got=%h exp=%h", act_vec, exp_vec());
      end
      step(1'b0, 0, 1'b0);
      total++;
      if (err !== 1'b0) begin
         bad++; $display("FAIL err_single_pulse got=%b exp=0", err);
      end
      step(1'b1, 9, 1'b0);
      total++;
      if (err !== 1'b1 || act_vec !== exp_vec()) begin
         bad++; $display("FAIL err_sub_idle got=%h exp=%h", act_vec, exp_vec());
      end
      step(1'b1, 1, 1'b0); step(1'b1, 8, 1'b0); step(1'b1, 2, 1'b0);
      step(1'b1, 8, 1'b0);
      total++;
      if (err !== 1'b1 || load !== 1'b0 || act_vec !== exp_vec()) begin
         bad++; $display("FAIL err_add_got_b got=%h exp=%h", act_vec, exp_vec());
      end
      step(1'b1, 13, 1'b0);
      total++;
      if (act_vec !== exp_vec()) begin
         bad++; $display("FAIL err_clear got=%h exp=%h", act_vec, exp_vec());
      end
   endtask

   task automatic test_drop();
      step(1'b0, 0, 1'b1);
      for (int r = 0; r < 4; r++) begin
         step(1'b1, 1, 1'b0); step(1'b1, 8, 1'b0); step(1'b1, 2, 1'b0);
         step(1'b1, 12, 1'b0);
         for (int i = 0; i < LC + 1; i++) begin
            step(1'b1, 4, 1'b0);
            total++;
            if (act_vec !== exp_vec()) begin
               bad++; $display("FAIL drop[%0d.%0d] got=%h exp=%h", r, i, act_vec, exp_vec());
            end
         end
      end
      total++;
      if (drop_cnt !== 4'd15) begin
         bad++; $display("FAIL drop_saturate got=%0d exp=15", drop_cnt);
      end
   endtask

   task automatic test_recall_clear();
      step(1'b1, 7, 1'b0); step(1'b1, 14, 1'b0);
      total++;
      if (addr !== 1'b1) begin
         bad++; $display("FAIL recall_first got=%b exp=1", addr);
      end
      step(1'b1, 8, 1'b0); step(1'b1, 14, 1'b0);
      total++;
      if (addr !== 1'b0) begin
         bad++; $display("FAIL recall_second got=%b exp=0", addr);
      end
      step(1'b1, 3, 1'b0); step(1'b1, 12, 1'b0);
      total++;
      if ({a, b, op, load} !== {3'd7, 3'd3, 2'b00, 1'b1}) begin
         bad++; $display("FAIL recall_entry got a=%0d b=%0d op=%b load=%b exp a=7 b=3 op=00 load=1",
                         a, b, op, load);
      end
      for (int i = 0; i < LC + 1; i++) step(1'b0, 0, 1'b0);
      step(1'b1, 3, 1'b0); step(1'b1, 11, 1'b0); step(1'b1, 13, 1'b0);
      total++;
      if ({a, b, op, err, key_ready} !== {3'd7, 3'd3, 2'b00, 1'b0, 1'b1}) begin
         bad++; $display("FAIL clear_retain got a=%0d b=%0d op=%b err=%b rdy=%b exp a=7 b=3 op=00 err=0 rdy=1",
                         a, b, op, err, key_ready);
      end
      step(1'b1, 12, 1'b0);
      total++;
      if (err !== 1'b1) begin
         bad++; $display("FAIL clear_to_idle got err=%b exp=1", err);
      end
      step(1'b1, 15, 1'b0);
      total++;
      if (act_vec !== exp_vec()) begin
         bad++; $display("FAIL reserved_key got=%h exp=%h", act_vec, exp_vec());
      end
   endtask

   task automatic test_reset_in_load();
      step(1'b1, 2, 1'b0); step(1'b1, 10, 1'b0); step(1'b1, 5, 1'b0);
      step(1'b1, 12, 1'b0);
      step(1'b0, 0, 1'b0);
      total++;
      if (load !== 1'b1) begin
         bad++; $display("FAIL rst_load_pre got load=%b exp=1", load);
      end
      step(1'b1, 4, 1'b1);
      total++;
      if (act_vec !== 16'h8000) begin
         bad++; $display("FAIL rst_in_load got=%h exp=%h", act_vec, 16'h8000);
      end
      step(1'b0, 0, 1'b0);
      total++;
      if (act_vec !== exp_vec()) begin
         bad++; $display("FAIL rst_in_load_after got=%h exp=%h", act_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic v, r;
      int   c;
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 149) == 0);
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 4) == 0) ? 12 : int'($urandom_range(0, 15));
         step(v, c, r);
         total++;
         if (act_vec !== exp_vec()) begin
            bad++; $display("FAIL random[%0d] got=%h exp=%h", i, act_vec, exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
      model_update(1'b0, 0, 1'b1);
      #2;
      test_reset();
      test_basic();
      test_last_wins();
      test_errors();
      test_drop();
      test_recall_clear();
      test_reset_in_load();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_key_entry.md
CALC_KEY_ENTRY -- requirements
Module: calc_key_entry

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 1, width in clk cycles of the load pulse (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-005 SHALL have port key_code  input  4  key: 0-7 digit, 8 ADD, 9 SUB, 10 MUL, 11 DIV, 12 ENTER, 13 CLEAR, 14 RECALL, 15 reserved.
REQ-006 SHALL have port key_ready  output  1  high when a key presented this cycle will be accepted.
REQ-007 SHALL have port a  output  3  committed operand A to calculator.
REQ-008 SHALL have port b  output  3  committed operand B to calculator.
REQ-009 SHALL have port op  output  2  committed operation: ADD 00, SUB 01, MUL 10, DIV 11.
REQ-010 SHALL have port load  output  1  calculator load strobe.
REQ-011 SHALL have port addr  output  1  calculator memory-slot select for display.
REQ-012 SHALL have port err  output  1  one-cycle pulse on an illegal key sequence.
REQ-013 SHALL have port drop_cnt  output  4  saturating count of keys dropped while key_ready low.

Function
REQ-014 SHALL implement FSM states IDLE, GOT_A, GOT_OP, GOT_B, LOAD, HOLD.
REQ-015 Key accepted only when key_valid=1 and key_ready=1; key_ready=1 in IDLE, GOT_A, GOT_OP, GOT_B, else 0.
REQ-016 IDLE: digit -> stage A, go GOT_A; operator or ENTER -> err, stay.
REQ-017 GOT_A: digit -> overwrite staged A, stay; operator -> stage op, go GOT_OP; ENTER -> err, stay.
REQ-018 GOT_OP: operator -> overwrite staged op, stay; digit -> stage B, go GOT_B; ENTER -> err, stay.
REQ-019 GOT_B: digit -> overwrite staged B, stay; ENTER -> copy staged A/B/op to outputs a/b/op, go LOAD; operator -> err, stay.
REQ-020 a/b/op SHALL change only on the ENTER acceptance edge and hold until the next accepted ENTER.
REQ-021 LOAD: load=1 for exactly LOAD_CYCLES cycles, then HOLD; a/b/op stable throughout.
REQ-022 HOLD: load=0 for one cycle, then IDLE; guarantees a/b/op stable one cycle after load falls.
REQ-023 CLEAR in any accepting state -> IDLE, staged values zeroed; committed a/b/op and addr unchanged; no err.
REQ-024 RECALL in any accepting state -> addr toggles, state and staged values unchanged.
REQ-025 Code 15 accepted and ignored: no state change, no err.
REQ-026 key_valid=1 while key_ready=0 -> key discarded, drop_cnt += 1, saturating at 15.
REQ-027 err is registered, asserted the cycle after the offending key, never two consecutive cycles from one key.
REQ-028 load and key_ready SHALL be registered/state-decoded outputs, glitch-free.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE, a=0, b=0, op=00, load=0, addr=0, err=0, drop_cnt=0, staged values 0.
REQ-030 rst during LOAD SHALL terminate load the following cycle (load=0) with no partial pulse continuation.
REQ-031 rst SHALL take priority over any simultaneous key_valid.

Structure
REQ-032 Package calc_pkg SHALL hold key-code constants, op encodings, FSM state encoding, and the LOAD_CYCLES legal range.
REQ-033 One sub-module calc_key_decode (combinational: key_code -> is_digit, is_op, op value, is_enter, is_clear, is_recall) SHALL be instantiated.

Verification
REQ-034 Keys 5, ADD(8), 3, ENTER(12) -> a=101, b=011, op=00, load high LOAD_CYCLES cycles starting 1 cycle after ENTER, then key_ready low 1 more cycle.
REQ-035 Keys 6, SUB, MUL, 2, 1, ENTER -> a=110, b=001, op=10 (last operator and last digit win).
REQ-036 ENTER in IDLE, SUB in IDLE, ADD in GOT_B -> err pulse each, state unchanged, no load.
REQ-037 Key 4 presented during LOAD, repeated 20 times across multiple LOADs -> each ignored, drop_cnt saturates at 15.
REQ-038 RECALL twice mid-entry -> addr 0->1->0, subsequent entry completes normally; CLEAR after 3, DIV -> IDLE, a/b/op retain previous values.
REQ-039 rst asserted in 2nd cycle of LOAD with LOAD_CYCLES=4 -> load=0 next cycle, all outputs at reset values.
